// File: rtl/collision_detector_pkg.sv
// Shared types and constants for the collision detector: obstacle payload, hitbox geometry,
// scan and jump state encodings.
package collision_detector_pkg;

  localparam int unsigned NUM_OBSTACLES = 10;
  localparam int unsigned POS_W         = 11;
  localparam int unsigned CMP_W         = 12;
  localparam int unsigned IDX_W         = 4;
  localparam int unsigned JUMP_W        = 6;
  localparam int unsigned LIVES_W       = 2;
  localparam int unsigned LANE_W        = 2;

  localparam logic [POS_W-1:0]   PLAYER_X       = 11'd100;
  localparam logic [POS_W-1:0]   PLAYER_WIDTH   = 11'd32;
  localparam logic [POS_W-1:0]   OBSTACLE_WIDTH = 11'd24;
  localparam logic [JUMP_W-1:0]  JUMP_FRAMES    = 6'd24;
  localparam logic [LIVES_W-1:0] NUM_LIVES      = 2'd3;
  localparam logic [JUMP_W-1:0]  GRACE_FRAMES   = 6'd60;
  localparam logic [1:0]         SPRITE_TALL    = 2'd3;

  // Obstacle occupies [position - OBSTACLE_WIDTH, position) on its lane.
  typedef struct packed {
    logic              active;
    logic [LANE_W-1:0] lane;
    logic [POS_W-1:0]  position;
    logic [1:0]        sprite_type;
  } obstacle_t;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_SNAP,
    SCAN_RUN,
    SCAN_REPORT
  } scan_state_t;

  typedef enum logic {
    JUMP_GROUND,
    JUMP_AIR
  } jump_state_t;

endpackage

// File: rtl/collision_detector_hitbox_check.sv
// Combinational overlap test of one obstacle against the player hitbox for the snapshotted
// lane and airborne state; tall sprites cannot be jumped over.
module collision_detector_hitbox_check
  import collision_detector_pkg::*;
(
  input  obstacle_t         obstacle,
  input  logic [LANE_W-1:0] snap_lane,
  input  logic              snap_airborne,
  output logic              hit_c
);

  logic [CMP_W-1:0] pos_w;
  logic [CMP_W-1:0] lo_w;
  logic [CMP_W-1:0] hi_w;

  // Widened by one bit so the right edge of the window cannot wrap.
  assign pos_w = CMP_W'(obstacle.position);
  assign lo_w  = CMP_W'(PLAYER_X);
  assign hi_w  = CMP_W'(PLAYER_X) + CMP_W'(PLAYER_WIDTH) + CMP_W'(OBSTACLE_WIDTH);

  assign hit_c = obstacle.active
              && (obstacle.lane == snap_lane)
              && (pos_w > lo_w)
              && (pos_w < hi_w)
              && !(snap_airborne && (obstacle.sprite_type != SPRITE_TALL));

endmodule

// File: rtl/collision_detector.sv
// Per-frame sequential scan of the obstacle array against the player hitbox, plus the
// player jump window. Build option: define LIVES_ON_EN for multiple lives with a grace window.
module collision_detector
  import collision_detector_pkg::*;
(
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              game_reset,
  input  logic                              frame_trigger,
  input  obstacle_t [NUM_OBSTACLES-1:0]     obstacles_in,
  input  logic [LANE_W-1:0]                 player_lane,
  input  logic                              player_jump,
  output logic                              player_airborne,
  output logic                              collision_out,
  output logic                              game_over,
  output logic [LIVES_W-1:0]                lives_out
);

`ifdef LIVES_ON_EN
  localparam logic [LIVES_W-1:0] LIVES_RESET = NUM_LIVES;
`else
  localparam logic [LIVES_W-1:0] LIVES_RESET = 2'd1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBSTACLES - 1);

  scan_state_t        scan_q, scan_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LANE_W-1:0]  snap_lane_q, snap_lane_d;
  logic               snap_air_q, snap_air_d;
  logic               hit_acc_q, hit_acc_d;
  jump_state_t        jump_q, jump_d;
  logic [JUMP_W-1:0]  jump_cnt_q, jump_cnt_d;
  logic               collision_d;
  logic               game_over_d;
  logic [LIVES_W-1:0] lives_d;
  logic               hit_c;
  logic               frame_hit;
`ifdef LIVES_ON_EN
  logic [JUMP_W-1:0]  grace_q, grace_d;
`endif

  collision_detector_hitbox_check u_hitbox_check (
    .obstacle      (obstacles_in[idx_q]),
    .snap_lane     (snap_lane_q),
    .snap_airborne (snap_air_q),
    .hit_c         (hit_c)
  );

  assign player_airborne = (jump_q == JUMP_AIR);
  assign frame_hit       = hit_acc_q | hit_c;

  // Next-state logic for the scan and jump machines and all registered outputs.
  always_comb begin
    scan_d      = scan_q;
    idx_d       = idx_q;
    snap_lane_d = snap_lane_q;
    snap_air_d  = snap_air_q;
    hit_acc_d   = hit_acc_q;
    jump_d      = jump_q;
    jump_cnt_d  = jump_cnt_q;
    collision_d = 1'b0;
    game_over_d = game_over;
    lives_d     = lives_out;
`ifdef LIVES_ON_EN
    grace_d     = grace_q;
`endif

    if (game_reset) begin
      scan_d      = SCAN_IDLE;
      idx_d       = '0;
      snap_lane_d = '0;
      snap_air_d  = 1'b0;
      hit_acc_d   = 1'b0;
      jump_d      = JUMP_GROUND;
      jump_cnt_d  = '0;
      game_over_d = 1'b0;
      lives_d     = LIVES_RESET;
`ifdef LIVES_ON_EN
      grace_d     = '0;
`endif
    end else begin
      // Jump window advances once per frame; the landing frame ignores a held jump.
      if (frame_trigger && !game_over) begin
        if (jump_q == JUMP_GROUND) begin
          if (player_jump) begin
            jump_d     = JUMP_AIR;
            jump_cnt_d = JUMP_FRAMES - 6'd1;
          end
        end else if (jump_cnt_q != '0) begin
          jump_cnt_d = jump_cnt_q - 6'd1;
        end else begin
          jump_d = JUMP_GROUND;
        end
`ifdef LIVES_ON_EN
        if (grace_q != '0) grace_d = grace_q - 6'd1;
`endif
      end

      case (scan_q)
        SCAN_IDLE: begin
          if (frame_trigger && !game_over) scan_d = SCAN_SNAP;
        end
        SCAN_SNAP: begin
          snap_lane_d = player_lane;
          snap_air_d  = (jump_q == JUMP_AIR);
          hit_acc_d   = 1'b0;
          idx_d       = '0;
          scan_d      = SCAN_RUN;
        end
        SCAN_RUN: begin
          hit_acc_d = frame_hit;
          if (idx_q == LAST_IDX) begin
            scan_d = SCAN_REPORT;
            // Resolved here so the pulse is visible during the report cycle.
            if (frame_hit) begin
`ifdef LIVES_ON_EN
              if (grace_q == '0) begin
                collision_d = 1'b1;
                lives_d     = lives_out - 2'd1;
                if (lives_out == 2'd1) game_over_d = 1'b1;
                else                   grace_d     = GRACE_FRAMES;
              end
`else
              collision_d = 1'b1;
              game_over_d = 1'b1;
              lives_d     = '0;
`endif
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        SCAN_REPORT: scan_d = SCAN_IDLE;
        default:     scan_d = SCAN_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scan_q        <= SCAN_IDLE;
      idx_q         <= '0;
      snap_lane_q   <= '0;
      snap_air_q    <= 1'b0;
      hit_acc_q     <= 1'b0;
      jump_q        <= JUMP_GROUND;
      jump_cnt_q    <= '0;
      collision_out <= 1'b0;
      game_over     <= 1'b0;
      lives_out     <= LIVES_RESET;
`ifdef LIVES_ON_EN
      grace_q       <= '0;
`endif
    end else begin
      scan_q        <= scan_d;
      idx_q         <= idx_d;
      snap_lane_q   <= snap_lane_d;
      snap_air_q    <= snap_air_d;
      hit_acc_q     <= hit_acc_d;
      jump_q        <= jump_d;
      jump_cnt_q    <= jump_cnt_d;
      collision_out <= collision_d;
      game_over     <= game_over_d;
      lives_out     <= lives_d;
`ifdef LIVES_ON_EN
      grace_q       <= grace_d;
`endif
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed edge cases plus random frames against
// a frame-level behavioural model. Honours LIVES_ON_EN when defined.
module tb_collision_detector;
  import collision_detector_pkg::*;

  localparam int PX = 100;
  localparam int PW = 32;
  localparam int OW = 24;
  localparam int JF = 24;
`ifdef LIVES_ON_EN
  localparam int LIVES0 = 3;
  localparam int GF     = 60;
`else
  localparam int LIVES0 = 1;
`endif

  logic                          clk_in = 1'b0;
  logic                          rst_in;
  logic                          game_reset;
  logic                          frame_trigger;
  obstacle_t [NUM_OBSTACLES-1:0] obstacles;
  logic [1:0]                    player_lane;
  logic                          player_jump;
  logic                          player_airborne;
  logic                          collision_out;
  logic                          game_over;
  logic [1:0]                    lives_out;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model state: frames of airtime left including the current one.
  int m_air_left;
  int m_lives;
  int m_grace;
  bit m_go;

  collision_detector dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .game_reset      (game_reset),
    .frame_trigger   (frame_trigger),
    .obstacles_in    (obstacles),
    .player_lane     (player_lane),
    .player_jump     (player_jump),
    .player_airborne (player_airborne),
    .collision_out   (collision_out),
    .game_over       (game_over),
    .lives_out       (lives_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_air_left = 0;
    m_lives    = LIVES0;
    m_grace    = 0;
    m_go       = 1'b0;
  endtask

  task automatic model_frame(input bit jump, input logic [1:0] lane, output bit pulse);
    bit hit;
    int p;
    pulse = 1'b0;
    if (!m_go) begin
      if (m_air_left > 0) m_air_left--;
      else if (jump)      m_air_left = JF;
      if (m_grace > 0) m_grace--;
      hit = 1'b0;
      for (int s = 0; s < NUM_OBSTACLES; s++) begin
        p = int'(obstacles[s].position);
        if (obstacles[s].active && obstacles[s].lane == lane && p > PX && p < PX + PW + OW &&
            (m_air_left == 0 || obstacles[s].sprite_type == 2'd3))
          hit = 1'b1;
      end
      if (hit) begin
`ifdef LIVES_ON_EN
        if (m_grace == 0) begin
          pulse = 1'b1;
          m_lives--;
          if (m_lives == 0) m_go = 1'b1;
          else              m_grace = GF;
        end
`else
        pulse   = 1'b1;
        m_lives = 0;
        m_go    = 1'b1;
`endif
      end
    end
  endtask

  task automatic clear_obs();
    obstacles = '0;
  endtask

  task automatic set_obs(input int slot, input bit act, input int lane, input int pos, input int spr);
    obstacles[slot].active      = act;
    obstacles[slot].lane        = 2'(lane);
    obstacles[slot].position    = 11'(pos);
    obstacles[slot].sprite_type = 2'(spr);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_air"}, int'(player_airborne), 0);
    check_val({tag, "_col"}, int'(collision_out), 0);
    check_val({tag, "_go"}, int'(game_over), 0);
    check_val({tag, "_lives"}, int'(lives_out), LIVES0);
  endtask

  task automatic do_game_reset(input string tag);
    @(posedge clk_in); #1 game_reset = 1'b1;
    @(posedge clk_in); #1 game_reset = 1'b0;
    model_reset();
    @(negedge clk_in);
    check_idle_outputs(tag);
  endtask

  // One frame: trigger at cycle 0, observe cycles 1..14, lane changed after the snapshot.
  task automatic run_frame(input string tag, input logic [1:0] lane, input bit jump);
    bit exp_pulse;
    int pulses;
    int pulse_cyc;
    player_lane = lane;
    player_jump = jump;
    model_frame(jump, lane, exp_pulse);
    @(posedge clk_in); #1 frame_trigger = 1'b1;
    @(posedge clk_in); #1 frame_trigger = 1'b0;
    pulses    = 0;
    pulse_cyc = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_in);
      if (c == 1) check_val({tag, "_air"}, int'(player_airborne), int'(m_air_left > 0));
      if (c == 3) player_lane = 2'($urandom_range(0, 3));
      if (collision_out) begin
        pulses++;
        pulse_cyc = c;
      end
    end
    check_val({tag, "_pulses"}, pulses, int'(exp_pulse));
    if (exp_pulse) check_val({tag, "_lat"}, pulse_cyc, 12);
    check_val({tag, "_go"}, int'(game_over), int'(m_go));
    check_val({tag, "_lives"}, int'(lives_out), m_lives);
  endtask

  task automatic reset_if_over(input string tag);
    if (m_go) do_game_reset(tag);
  endtask

  initial begin
    int pulses;
    rst_in        = 1'b1;
    game_reset    = 1'b0;
    frame_trigger = 1'b0;
    player_lane   = 2'd0;
    player_jump   = 1'b0;
    clear_obs();
    model_reset();
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check_idle_outputs("rst");

    // Jump over a low obstacle, then a tall one in the air still hits.
    set_obs(4, 1'b1, 1, PX + 20, 0);
    run_frame("jump_low", 2'd1, 1'b1);
    set_obs(4, 1'b1, 1, PX + 20, 3);
    run_frame("air_tall", 2'd1, 1'b0);
    do_game_reset("gr1");

    // Basic hit on the ground.
    set_obs(4, 1'b1, 1, PX + 20, 0);
    run_frame("basic", 2'd1, 1'b0);
    do_game_reset("gr2");

    // Window edges, inactive slot, lane mismatch.
    clear_obs(); set_obs(2, 1'b1, 0, PX, 1);
    run_frame("edge_lo", 2'd0, 1'b0);
    clear_obs(); set_obs(2, 1'b1, 0, PX + PW + OW, 1);
    run_frame("edge_hi", 2'd0, 1'b0);
    clear_obs(); set_obs(2, 1'b1, 0, PX + PW + OW - 1, 1);
    set_obs(5, 1'b0, 2, PX + 10, 0);
    run_frame("inactive_lastpix", 2'd2, 1'b0);
    clear_obs(); set_obs(7, 1'b1, 2, PX + 10, 0);
    run_frame("lane_mis", 2'd1, 1'b0);
    clear_obs(); set_obs(2, 1'b1, 0, PX + 1, 1);
    run_frame("edge_lo1", 2'd0, 1'b0);
    reset_if_over("gr3");

    // First and last slot hit in one frame, then triggers after game over.
    clear_obs();
    set_obs(0, 1'b1, 2, PX + 5, 2);
    set_obs(9, 1'b1, 2, PX + 50, 0);
    run_frame("two_hits", 2'd2, 1'b0);
`ifndef LIVES_ON_EN
    run_frame("after_go", 2'd2, 1'b1);
`endif
    do_game_reset("gr4");

    // Held jump: airborne window, single ground frame, re-jump.
    clear_obs();
    for (int f = 0; f < 30; f++) run_frame($sformatf("hold%0d", f), 2'd0, 1'b1);
    do_game_reset("gr5");

    // Restart in the middle of a scan that would have hit.
    clear_obs(); set_obs(3, 1'b1, 1, PX + 30, 3);
    player_lane = 2'd1;
    player_jump = 1'b1;
    @(posedge clk_in); #1 frame_trigger = 1'b1;
    @(posedge clk_in); #1 frame_trigger = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_val("mid_air_before", int'(player_airborne), 1);
    game_reset = 1'b1;
    @(posedge clk_in); #1 game_reset = 1'b0;
    check_idle_outputs("mid_reset");
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (collision_out) pulses++;
    end
    check_val("mid_reset_pulses", pulses, 0);
    model_reset();
    player_jump = 1'b0;

`ifdef LIVES_ON_EN
    // Lives and grace: hits presented on frames 0, 10, 70, 140.
    for (int f = 0; f <= 140; f++) begin
      clear_obs();
      if (f == 0 || f == 10 || f == 70 || f == 140) set_obs(6, 1'b1, 0, PX + 40, 0);
      run_frame($sformatf("lives%0d", f), 2'd0, 1'b0);
    end
    check_val("lives_final_go", int'(game_over), 1);
    do_game_reset("gr6");
`endif

    // Random frames against the model.
    for (int f = 0; f < 150; f++) begin
      for (int s = 0; s < NUM_OBSTACLES; s++) begin
        set_obs(s, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                            : int'($urandom_range(PX - 8, PX + PW + OW + 8)),
                int'($urandom_range(0, 3)));
      end
      run_frame($sformatf("rnd%0d", f), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      if (m_go && $urandom_range(0, 3) == 0)
        run_frame($sformatf("rnd_go%0d", f), 2'($urandom_range(0, 2)), 1'b1);
      reset_if_over($sformatf("rnd_gr%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
